manchester_encoder_tx: RTL

- Transmit-side counterpart of the Manchester receive path. Accepts bytes on a valid/ready stream and frames them as a 16-bit preamble 0xAAD5 followed by exactly FRAME_SIZE bytes, all MSB-first.
- Manchester-encodes every bit onto a single serial line, with a line-enable for the driver.
- Sits between the packet source and the output serializer/IO buffer, feeding the same link the Manchester decoder receives.

---
 rtl/manchester_encoder_tx.sv | 179 +++++++++++++++++
 1 files changed

// File: rtl/manchester_encoder_tx.sv
// Manchester (IEEE 802.3) frame transmitter: 0xAAD5 preamble then FRAME_SIZE bytes, MSB first.
// Missing bytes are padded with 0x00 so every frame has a fixed length.
module manchester_encoder_tx #(
  parameter int unsigned FRAME_SIZE = 6,
  parameter int unsigned HALF_CLKS  = 4,
  parameter int unsigned IFG_BITS   = 4
) (
  input  logic       aclk,
  input  logic       aresetn,
  input  logic [7:0] s_tdata,
  input  logic       s_tvalid,
  output logic       s_tready,
  output logic       tx_out,
  output logic       tx_en,
  output logic       busy,
  output logic       frame_done,
  output logic       underrun
);

  localparam logic [1:0] StIdle     = 2'd0;
  localparam logic [1:0] StPreamble = 2'd1;
  localparam logic [1:0] StData     = 2'd2;
  localparam logic [1:0] StGap      = 2'd3;

  localparam int unsigned GapClks = IFG_BITS * 2 * HALF_CLKS;
  localparam int unsigned TmrW    = (HALF_CLKS > 1) ? $clog2(HALF_CLKS) : 1;
  localparam int unsigned ByteW   = (FRAME_SIZE > 1) ? $clog2(FRAME_SIZE) : 1;
  localparam int unsigned SlotW   = $clog2(FRAME_SIZE + 1);
  localparam int unsigned GapW    = (GapClks > 1) ? $clog2(GapClks) : 1;

  localparam logic [15:0]      Preamble = 16'hAAD5;
  localparam logic [TmrW-1:0]  TmrLast  = TmrW'(HALF_CLKS - 1);
  localparam logic [ByteW-1:0] ByteLast = ByteW'(FRAME_SIZE - 1);
  localparam logic [SlotW-1:0] SlotMax  = SlotW'(FRAME_SIZE);
  localparam logic [GapW-1:0]  GapLast  = GapW'(GapClks - 1);

  logic [1:0]       state_q, state_d;
  logic [7:0]       hold_q, hold_d;
  logic             hold_vld_q, hold_vld_d;
  logic [SlotW-1:0] slots_q, slots_d;
  logic [TmrW-1:0]  tmr_q, tmr_d;
  logic             half_q, half_d;
  logic [3:0]       bit_idx_q, bit_idx_d;
  logic [ByteW-1:0] byte_cnt_q, byte_cnt_d;
  logic [15:0]      shift_q, shift_d;
  logic [GapW-1:0]  gap_q, gap_d;
  logic             tx_out_q, tx_out_d;
  logic             tx_en_q, tx_en_d;
  logic             frame_done_q, underrun_q;

  logic accept, load, pad, frame_end, sym_end;

  assign s_tready = aresetn && (state_q != StGap) && !hold_vld_q && (slots_q < SlotMax);
  assign accept   = s_tvalid && s_tready;

  always_comb begin
    state_d    = state_q;
    hold_d     = hold_q;
    hold_vld_d = hold_vld_q;
    tmr_d      = tmr_q;
    half_d     = half_q;
    bit_idx_d  = bit_idx_q;
    byte_cnt_d = byte_cnt_q;
    shift_d    = shift_q;
    gap_d      = gap_q;
    load       = 1'b0;
    pad        = 1'b0;
    frame_end  = 1'b0;
    sym_end    = 1'b0;

    case (state_q)
      StIdle: begin
        if (accept) begin
          state_d    = StPreamble;
          shift_d    = Preamble;
          tmr_d      = '0;
          half_d     = 1'b0;
          bit_idx_d  = '0;
          byte_cnt_d = '0;
        end
      end
      StPreamble, StData: begin
        if (tmr_q != TmrLast) begin
          tmr_d = tmr_q + 1'b1;
        end else begin
          tmr_d  = '0;
          half_d = ~half_q;
          if (half_q) begin
            sym_end = (state_q == StPreamble) ? (bit_idx_q == 4'd15) : (bit_idx_q == 4'd7);
            if (!sym_end) begin
              shift_d   = {shift_q[14:0], 1'b0};
              bit_idx_d = bit_idx_q + 4'd1;
            end else if ((state_q == StData) && (byte_cnt_q == ByteLast)) begin
              state_d   = StGap;
              gap_d     = '0;
              bit_idx_d = '0;
            end else begin
              // Next byte starts on the very next cycle, keeping the bit stream gapless
              load       = 1'b1;
              state_d    = StData;
              bit_idx_d  = '0;
              byte_cnt_d = (state_q == StPreamble) ? {ByteW{1'b0}} : byte_cnt_q + 1'b1;
            end
          end
        end
      end
      StGap: begin
        if (gap_q == GapLast) begin
          state_d   = StIdle;
          gap_d     = '0;
          frame_end = 1'b1;
        end else begin
          gap_d = gap_q + 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase

    if (load) begin
      if (hold_vld_q) begin
        shift_d    = {hold_q, 8'h00};
        hold_vld_d = 1'b0;
      end else begin
        shift_d = '0;
        pad     = 1'b1;
      end
    end
    // An accept in the load cycle refills hold after the old byte moved to the shifter
    if (accept) begin
      hold_d     = s_tdata;
      hold_vld_d = 1'b1;
    end

    slots_d  = frame_end ? '0 : slots_q + SlotW'(accept) + SlotW'(pad);
    tx_en_d  = (state_d == StPreamble) || (state_d == StData);
    tx_out_d = tx_en_d && (half_d ? shift_d[15] : ~shift_d[15]);
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state_q      <= StIdle;
      hold_q       <= '0;
      hold_vld_q   <= 1'b0;
      slots_q      <= '0;
      tmr_q        <= '0;
      half_q       <= 1'b0;
      bit_idx_q    <= '0;
      byte_cnt_q   <= '0;
      shift_q      <= '0;
      gap_q        <= '0;
      tx_out_q     <= 1'b0;
      tx_en_q      <= 1'b0;
      frame_done_q <= 1'b0;
      underrun_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      hold_q       <= hold_d;
      hold_vld_q   <= hold_vld_d;
      slots_q      <= slots_d;
      tmr_q        <= tmr_d;
      half_q       <= half_d;
      bit_idx_q    <= bit_idx_d;
      byte_cnt_q   <= byte_cnt_d;
      shift_q      <= shift_d;
      gap_q        <= gap_d;
      tx_out_q     <= tx_out_d;
      tx_en_q      <= tx_en_d;
      frame_done_q <= (state_d == StGap) && (state_q != StGap);
      underrun_q   <= pad;
    end
  end

  assign tx_out     = tx_out_q;
  assign tx_en      = tx_en_q;
  assign busy       = (state_q != StIdle);
  assign frame_done = frame_done_q;
  assign underrun   = underrun_q;

endmodule
